// File: rtl/rtsnoc_pkg.sv
// Shared definitions for the RTSNoC port buffer: flit geometry and RX handshake states.
// Flit layout, MSB to LSB: {X_orig, Y_orig, local_orig[2:0], X_dst, Y_dst, local_dst[2:0], data}.
package rtsnoc_pkg;

  localparam int unsigned LOCAL_ADR_W = 3;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_ACK     = 2'd1,
    RX_BLOCKED = 2'd2
  } rx_state_e;

  function automatic int unsigned hdr_width(input int unsigned sx, input int unsigned sy);
    return 2 * sx + 2 * sy + 2 * LOCAL_ADR_W;
  endfunction

  function automatic int unsigned bus_width(input int unsigned dw, input int unsigned sx,
                                            input int unsigned sy);
    return dw + hdr_width(sx, sy);
  endfunction

  function automatic int unsigned off_local_dst(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned off_y_dst(input int unsigned dw);
    return dw + LOCAL_ADR_W;
  endfunction

  function automatic int unsigned off_x_dst(input int unsigned dw, input int unsigned sy);
    return off_y_dst(dw) + sy;
  endfunction

  function automatic int unsigned off_local_orig(input int unsigned dw, input int unsigned sx,
                                                 input int unsigned sy);
    return off_x_dst(dw, sy) + sx;
  endfunction

  function automatic int unsigned off_y_orig(input int unsigned dw, input int unsigned sx,
                                             input int unsigned sy);
    return off_local_orig(dw, sx, sy) + LOCAL_ADR_W;
  endfunction

  function automatic int unsigned off_x_orig(input int unsigned dw, input int unsigned sx,
                                             input int unsigned sy);
    return off_y_orig(dw, sx, sy) + sy;
  endfunction

endpackage

// File: rtl/rtsnoc_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module rtsnoc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** LOG2;
  localparam logic [LOG2:0] FULL_CNT = {1'b1, {LOG2{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LOG2:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + LOG2'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (LOG2 + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/rtsnoc_port_buffer.sv
// Elastic buffer between a Wishbone bridge and one RTSNoC router local port.
// TX and RX FIFOs decouple the wr/wait and nd/rd handshakes; misaddressed RX flits are dropped.
module rtsnoc_port_buffer
  import rtsnoc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SOC_SIZE_X    = 1,
  parameter int unsigned SOC_SIZE_Y    = 1,
  parameter logic [2:0]  NOC_LOCAL_ADR = 3'd0,
  parameter int unsigned NOC_X         = 0,
  parameter int unsigned NOC_Y         = 0,
  parameter int unsigned FIFO_LOG2     = 2,
  localparam int unsigned BUS_W        = bus_width(DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] br_din_i,
  input  logic             br_wr_i,
  output logic             br_wait_o,
  output logic [BUS_W-1:0] br_dout_o,
  output logic             br_nd_o,
  input  logic             br_rd_i,
  output logic [BUS_W-1:0] rtr_din_o,
  output logic             rtr_wr_o,
  input  logic             rtr_wait_i,
  input  logic [BUS_W-1:0] rtr_dout_i,
  input  logic             rtr_nd_i,
  output logic             rtr_rd_o,
  output logic [7:0]       drop_cnt_o,
  output logic             tx_ovf_o
);

  localparam int unsigned LDST_LSB = off_local_dst(DATA_WIDTH);
  localparam int unsigned YDST_LSB = off_y_dst(DATA_WIDTH);
  localparam int unsigned XDST_LSB = off_x_dst(DATA_WIDTH, SOC_SIZE_Y);

  // ---------------- TX path ----------------
  logic [BUS_W-1:0] tx_head;
  logic             tx_full, tx_empty, tx_go;
  logic [BUS_W-1:0] rtr_din_q, rtr_din_d;
  logic             rtr_wr_q, rtr_wr_d;
  logic             tx_ovf_q, tx_ovf_d;

  rtsnoc_sync_fifo #(.WIDTH(BUS_W), .LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (br_wr_i),
    .pop   (tx_go),
    .din   (br_din_i),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Gating on the registered strobe leaves an idle cycle for the router to raise wait.
  always_comb begin
    tx_go     = !tx_empty && !rtr_wait_i && !rtr_wr_q;
    rtr_wr_d  = tx_go;
    rtr_din_d = tx_go ? tx_head : rtr_din_q;
    tx_ovf_d  = tx_ovf_q || (br_wr_i && tx_full && !tx_go);
  end

  // ---------------- RX path ----------------
  logic [BUS_W-1:0] rx_head;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic             dst_match, drop_inc, rd_ack;
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             pres_q, pres_d, pres_go;
  logic             br_nd_q, br_nd_d;
  logic [BUS_W-1:0] br_dout_q, br_dout_d;

  rtsnoc_sync_fifo #(.WIDTH(BUS_W), .LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rtr_dout_i),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign dst_match = (rtr_dout_i[XDST_LSB +: SOC_SIZE_X] == SOC_SIZE_X'(NOC_X)) &&
                     (rtr_dout_i[YDST_LSB +: SOC_SIZE_Y] == SOC_SIZE_Y'(NOC_Y)) &&
                     (rtr_dout_i[LDST_LSB +: LOCAL_ADR_W] == NOC_LOCAL_ADR);

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rtr_nd_i) begin
          rx_state_d = (dst_match && rx_full) ? RX_BLOCKED : RX_ACK;
        end
      end
      RX_BLOCKED: begin
        if (!rx_full) rx_state_d = RX_ACK;
      end
      RX_ACK:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push  = 1'b0;
    drop_inc = 1'b0;
    rd_ack   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_push  = rtr_nd_i && dst_match && !rx_full;
        drop_inc = rtr_nd_i && !dst_match;
      end
      RX_BLOCKED: rx_push = !rx_full;
      RX_ACK:     rd_ack  = 1'b1;
      default: ;
    endcase
  end

  // The presented flit stays at the FIFO head until the bridge reads it.
  always_comb begin
    pres_go    = !rx_empty && !pres_q;
    rx_pop     = br_rd_i && pres_q;
    br_nd_d    = pres_go;
    br_dout_d  = pres_go ? rx_head : br_dout_q;
    pres_d     = rx_pop ? 1'b0 : (pres_go ? 1'b1 : pres_q);
    drop_cnt_d = (drop_inc && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rtr_din_q  <= '0;
      rtr_wr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_state_q <= RX_IDLE;
      drop_cnt_q <= '0;
      pres_q     <= 1'b0;
      br_nd_q    <= 1'b0;
      br_dout_q  <= '0;
    end else begin
      rtr_din_q  <= rtr_din_d;
      rtr_wr_q   <= rtr_wr_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_state_q <= rx_state_d;
      drop_cnt_q <= drop_cnt_d;
      pres_q     <= pres_d;
      br_nd_q    <= br_nd_d;
      br_dout_q  <= br_dout_d;
    end
  end

  assign br_wait_o  = tx_full;
  assign rtr_din_o  = rtr_din_q;
  assign rtr_wr_o   = rtr_wr_q;
  assign tx_ovf_o   = tx_ovf_q;
  assign rtr_rd_o   = rd_ack;
  assign drop_cnt_o = drop_cnt_q;
  assign br_nd_o    = br_nd_q;
  assign br_dout_o  = br_dout_q;

endmodule

// File: tb/tb_rtsnoc_port_buffer.sv
// Bench for rtsnoc_port_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_rtsnoc_port_buffer;

  localparam int unsigned BUS   = 42;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [BUS-1:0] br_din_i, br_dout_o, rtr_din_o, rtr_dout_i;
  logic           br_wr_i, br_wait_o, br_nd_o, br_rd_i;
  logic           rtr_wr_o, rtr_wait_i, rtr_nd_i, rtr_rd_o, tx_ovf_o;
  logic [7:0]     drop_cnt_o;

  always #5 clk = ~clk;

  rtsnoc_port_buffer #(
    .DATA_WIDTH   (32),
    .SOC_SIZE_X   (1),
    .SOC_SIZE_Y   (1),
    .NOC_LOCAL_ADR(3'd0),
    .NOC_X        (0),
    .NOC_Y        (0),
    .FIFO_LOG2    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_din_i  (br_din_i),
    .br_wr_i   (br_wr_i),
    .br_wait_o (br_wait_o),
    .br_dout_o (br_dout_o),
    .br_nd_o   (br_nd_o),
    .br_rd_i   (br_rd_i),
    .rtr_din_o (rtr_din_o),
    .rtr_wr_o  (rtr_wr_o),
    .rtr_wait_i(rtr_wait_i),
    .rtr_dout_i(rtr_dout_i),
    .rtr_nd_i  (rtr_nd_i),
    .rtr_rd_o  (rtr_rd_o),
    .drop_cnt_o(drop_cnt_o),
    .tx_ovf_o  (tx_ovf_o)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned nd_pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BUS-1:0] m_txq[$];
  logic [BUS-1:0] m_rxq[$];
  logic [BUS-1:0] e_rtr_din, e_br_dout;
  bit             e_rtr_wr, e_br_nd, e_ovf, m_pres;
  int unsigned    e_drop;
  int             m_phase;  // 0: waiting for a flit, 1: acknowledging, 2: stalled on full RX

  function automatic bit is_local(input logic [BUS-1:0] f);
    return (f[36] == 1'b0) && (f[35] == 1'b0) && (f[34:32] == 3'd0);
  endfunction

  task automatic model_step();
    bit go, rx_full, push_rx, go_p, pop_p;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      e_rtr_din = '0; e_br_dout = '0;
      e_rtr_wr = 0; e_br_nd = 0; e_ovf = 0; m_pres = 0;
      e_drop = 0; m_phase = 0;
      return;
    end
    go = (m_txq.size() != 0) && !rtr_wait_i && !e_rtr_wr;
    if (go) e_rtr_din = m_txq.pop_front();
    e_rtr_wr = go;
    if (br_wr_i) begin
      if (m_txq.size() < DEPTH) m_txq.push_back(br_din_i);
      else e_ovf = 1;
    end
    rx_full = (m_rxq.size() == DEPTH);
    push_rx = 0;
    case (m_phase)
      0: if (rtr_nd_i) begin
           if (!is_local(rtr_dout_i)) begin
             if (e_drop < 255) e_drop++;
             m_phase = 1;
           end else if (rx_full) m_phase = 2;
           else begin push_rx = 1; m_phase = 1; end
         end
      1: m_phase = 0;
      default: if (!rx_full) begin push_rx = 1; m_phase = 1; end
    endcase
    go_p  = (m_rxq.size() != 0) && !m_pres;
    pop_p = br_rd_i && m_pres;
    e_br_nd = go_p;
    if (go_p) begin e_br_dout = m_rxq[0]; m_pres = 1; end
    if (pop_p) begin void'(m_rxq.pop_front()); m_pres = 0; end
    if (push_rx) m_rxq.push_back(rtr_dout_i);
  endtask

  task automatic compare_all();
    check("rtr_wr_o",   rtr_wr_o,   e_rtr_wr);
    check("rtr_din_o",  rtr_din_o,  e_rtr_din);
    check("br_wait_o",  br_wait_o,  m_txq.size() == DEPTH);
    check("tx_ovf_o",   tx_ovf_o,   e_ovf);
    check("rtr_rd_o",   rtr_rd_o,   m_phase == 1);
    check("br_nd_o",    br_nd_o,    e_br_nd);
    check("br_dout_o",  br_dout_o,  e_br_dout);
    check("drop_cnt_o", drop_cnt_o, e_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (br_nd_o) nd_pulses++;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_rtr_wr"}, rtr_wr_o, 0);
    check({pfx, "_rtr_din"}, rtr_din_o, 0);
    check({pfx, "_br_wait"}, br_wait_o, 0);
    check({pfx, "_ovf"}, tx_ovf_o, 0);
    check({pfx, "_rtr_rd"}, rtr_rd_o, 0);
    check({pfx, "_br_nd"}, br_nd_o, 0);
    check({pfx, "_br_dout"}, br_dout_o, 0);
    check({pfx, "_drop"}, drop_cnt_o, 0);
  endtask

  task automatic do_reset();
    rst = 1; br_wr_i = 0; br_rd_i = 0; rtr_nd_i = 0; rtr_wait_i = 0;
    br_din_i = '0; rtr_dout_i = '0;
    tick(); tick();
    rst = 0;
  endtask

  // Router side: pulse nd, hold the flit, wait (bounded) for rd.
  task automatic send_flit(input logic [BUS-1:0] f, input int unsigned max_cycles, output bit acked);
    rtr_dout_i = f; rtr_nd_i = 1;
    tick();
    rtr_nd_i = 0; acked = 0;
    for (int unsigned i = 0; i < max_cycles && !acked; i++) begin
      if (rtr_rd_o) acked = 1;
      else tick();
    end
    if (acked) tick();
  endtask

  function automatic logic [BUS-1:0] tx_flit(input int unsigned i);
    logic [31:0] d;
    d = 32'hC0DE0000 + i;
    return {1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, d};
  endfunction

  function automatic logic [BUS-1:0] rx_flit(input int unsigned i);
    logic [31:0] d;
    d = 32'h55000000 + i;
    return {1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, d};
  endfunction

  function automatic logic [BUS-1:0] rand_flit();
    logic [63:0] r;
    logic [BUS-1:0] f;
    r = {$urandom, $urandom};
    f = r[BUS-1:0];
    if ($urandom_range(0, 3) != 0) f[36:32] = 5'd0;
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUS-1:0] f;
    bit acked, adjacent, prev, r_busy;
    int unsigned n;

    // 1: reset and minimum TX latency
    do_reset();
    check_zero("t1_rst");
    f = {1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 3'd0, 32'hAABBCCDD};
    br_din_i = f; br_wr_i = 1;
    tick();
    br_wr_i = 0;
    check("t1_wr_early", rtr_wr_o, 0);
    tick();
    check("t1_wr", rtr_wr_o, 1);
    check("t1_din", rtr_din_o, f);
    tick();
    check("t1_wr_pulse", rtr_wr_o, 0);

    // 2: TX back-pressure and overflow
    do_reset();
    rtr_wait_i = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      br_din_i = tx_flit(i); br_wr_i = 1;
      tick();
      check("t2_wait", br_wait_o, i == 3);
    end
    br_din_i = tx_flit(4);
    tick();
    br_wr_i = 0;
    check("t2_ovf", tx_ovf_o, 1);
    rtr_wait_i = 0;
    n = 0; prev = 0; adjacent = 0;
    for (int unsigned c = 0; c < 12; c++) begin
      tick();
      if (rtr_wr_o) begin
        check("t2_order", rtr_din_o, tx_flit(n));
        n++;
        if (prev) adjacent = 1;
      end
      prev = rtr_wr_o;
    end
    check("t2_count", n, 4);
    check("t2_spacing", adjacent, 0);
    check("t2_ovf_sticky", tx_ovf_o, 1);

    // 3: RX delivery and stability until read
    do_reset();
    f = {1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 32'h11223344};
    rtr_dout_i = f; rtr_nd_i = 1;
    tick();
    rtr_nd_i = 0;
    check("t3_rd", rtr_rd_o, 1);
    tick();
    check("t3_rd_once", rtr_rd_o, 0);
    check("t3_nd", br_nd_o, 1);
    check("t3_dout", br_dout_o, f);
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("t3_nd_low", br_nd_o, 0);
      check("t3_stable", br_dout_o, f);
    end
    br_rd_i = 1;
    tick();
    br_rd_i = 0;
    tick();
    check("t3_no_more", br_nd_o, 0);

    // 4: destination filter
    do_reset();
    nd_pulses = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      send_flit({5'd0, 1'b0, 1'b0, 3'd1, 32'hDEAD0000 + i}, 8, acked);
      check("t4_ack", acked, 1);
    end
    tick(); tick();
    check("t4_nd_count", nd_pulses, 0);
    check("t4_drop", drop_cnt_o, 3);

    // 5: RX full stalls the router until the bridge reads
    do_reset();
    nd_pulses = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      send_flit(rx_flit(i), 8, acked);
      check("t5_ack", acked, 1);
    end
    send_flit(rx_flit(4), 6, acked);
    check("t5_blocked", acked, 0);
    check("t5_head", br_dout_o, rx_flit(0));
    br_rd_i = 1;
    tick();
    br_rd_i = 0;
    acked = 0;
    for (int unsigned c = 0; c < 6 && !acked; c++) begin
      if (rtr_rd_o) acked = 1;
      else tick();
    end
    check("t5_unblock", acked, 1);
    tick();
    for (int unsigned k = 1; k < 5; k++) begin
      tick(); tick();
      check("t5_data", br_dout_o, rx_flit(k));
      br_rd_i = 1;
      tick();
      br_rd_i = 0;
    end
    tick(); tick();
    check("t5_nd_count", nd_pulses, 5);

    // 6: reset mid-operation
    do_reset();
    rtr_wait_i = 1;
    for (int unsigned i = 0; i < 2; i++) begin
      br_din_i = tx_flit(i); br_wr_i = 1;
      tick();
    end
    br_wr_i = 0;
    for (int unsigned i = 0; i < 4; i++) send_flit(rx_flit(i), 8, acked);
    send_flit(rx_flit(9), 3, acked);
    check("t6_blocked", acked, 0);
    rst = 1;
    tick();
    check_zero("t6_rst");
    rst = 0; rtr_wait_i = 0; rtr_dout_i = '0;
    n = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      tick();
      if (rtr_wr_o || br_nd_o || rtr_rd_o) n++;
    end
    check("t6_no_stale", n, 0);

    // random traffic
    do_reset();
    r_busy = 0;
    for (int unsigned c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 599) == 0);
      br_wr_i    = (m_txq.size() == DEPTH) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      br_din_i   = rand_flit();
      rtr_wait_i = ($urandom_range(0, 3) == 0);
      br_rd_i    = ($urandom_range(0, 2) == 0);
      rtr_nd_i   = 0;
      if (m_phase == 1) r_busy = 0;
      else if (!r_busy && $urandom_range(0, 2) == 0) begin
        rtr_dout_i = rand_flit();
        rtr_nd_i   = 1;
        r_busy     = 1;
      end
      tick();
      if (rst) r_busy = 0;
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
